fir_acc_reader: RTL and testbench



---
 rtl/fir_acc_reader_pkg.sv | 17 +
 rtl/fir_acc_reader_round_sat.sv | 39 +++
 rtl/fir_acc_reader.sv | 103 ++++++++++
 tb/tb_fir_acc_reader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_acc_reader_pkg.sv
// Shared types and default sizes for the FIR output path.
package fir_pkg;

    localparam int FIR_WIDTH = 16;
    localparam int FIR_FRAC  = 15;
    localparam int FIR_DEPTH = 4;
    localparam int ACC_W     = 2 * FIR_WIDTH + 6;

    typedef logic signed [ACC_W-1:0]     acc_t;
    typedef logic signed [FIR_WIDTH-1:0] smp_t;

    typedef struct packed {
        smp_t data;
        logic sat;
    } fifo_ent_t;

endpackage

// File: rtl/fir_acc_reader_round_sat.sv
// fir_round_sat: combinational round-half-up and saturate of a wide accumulator
// down to a WIDTH-bit sample.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int FRAC  = FIR_FRAC
) (
    input  logic signed [2*WIDTH+5:0] acc,
    output logic signed [WIDTH-1:0]   data,
    output logic                      sat
);

    localparam int ACC_BITS = 2 * WIDTH + 6;

    // One guard bit keeps the rounding add from overflowing.
    localparam logic signed [ACC_BITS:0] HALF    = {{ACC_BITS{1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [ACC_BITS:0] SMP_MAX = (ACC_BITS + 1)'((longint'(1) << (WIDTH - 1)) - 1);
    localparam logic signed [ACC_BITS:0] SMP_MIN = -SMP_MAX - 1;

    logic signed [ACC_BITS:0] sum;
    logic signed [ACC_BITS:0] q;

    always_comb begin
        sum = {acc[ACC_BITS-1], acc} + HALF;
        q   = sum >>> FRAC;
        if (q > SMP_MAX) begin
            data = SMP_MAX[WIDTH-1:0];
            sat  = 1'b1;
        end else if (q < SMP_MIN) begin
            data = SMP_MIN[WIDTH-1:0];
            sat  = 1'b1;
        end else begin
            data = q[WIDTH-1:0];
            sat  = 1'b0;
        end
    end

endmodule

// File: rtl/fir_acc_reader.sv
// fir_acc_reader: rounds/saturates accumulator results and buffers them in a FIFO.
// Optional saturation counter (sat_cnt, sat_cnt_clr) under FIR_ACC_READER_SATCNT_EN.
module fir_acc_reader
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int FRAC  = FIR_FRAC,
    parameter int DEPTH = FIR_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [2*WIDTH+5:0] acc_in,
    input  logic                      acc_valid,
    output logic                      acc_ready,
    output logic signed [WIDTH-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sat_flag
`ifdef FIR_ACC_READER_SATCNT_EN
    ,
    input  logic                      sat_cnt_clr,
    output logic [15:0]               sat_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic signed [WIDTH-1:0] rs_data;
    logic                    rs_sat;

    fir_round_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_round_sat (
        .acc  (acc_in),
        .data (rs_data),
        .sat  (rs_sat)
    );

    logic                    stage_vld;
    logic signed [WIDTH-1:0] stage_data;
    logic                    stage_sat;
    logic signed [WIDTH-1:0] mem_data [DEPTH];
    logic                    mem_sat  [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;
    logic                    accept;
    logic                    pop;

    // The staged entry holds a FIFO credit, so the stage-to-FIFO write never stalls.
    assign acc_ready = !rst && ((count + (AW + 1)'(stage_vld)) < (AW + 1)'(DEPTH));
    assign accept    = acc_valid && acc_ready;
    assign out_valid = (count != '0);
    assign out_data  = mem_data[rd_ptr];
    assign sat_flag  = mem_sat[rd_ptr];
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld  <= 1'b0;
            stage_data <= '0;
            stage_sat  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_sat[i]  <= 1'b0;
            end
        end else begin
            stage_vld <= accept;
            if (accept) begin
                stage_data <= rs_data;
                stage_sat  <= rs_sat;
            end
            if (stage_vld) begin
                mem_data[wr_ptr] <= stage_data;
                mem_sat[wr_ptr]  <= stage_sat;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({stage_vld, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIR_ACC_READER_SATCNT_EN
    always_ff @(posedge clk) begin
        if (rst || sat_cnt_clr) begin
            sat_cnt <= '0;
        end else if (pop && sat_flag && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_acc_reader.sv
// Self-checking bench for fir_acc_reader: directed vectors, backpressure,
// full-FIFO streaming, random traffic and mid-stream reset.
module tb_fir_acc_reader;

    localparam int WIDTH = 16;
    localparam int FRAC  = 15;
    localparam int DEPTH = 4;
    localparam int ACC_W = 2 * WIDTH + 6;

    logic                    clk;
    logic                    rst;
    logic signed [ACC_W-1:0] acc_in;
    logic                    acc_valid;
    logic                    acc_ready;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sat_flag;
`ifdef FIR_ACC_READER_SATCNT_EN
    logic                    sat_cnt_clr;
    logic [15:0]             sat_cnt;
`endif

    fir_acc_reader #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .acc_in      (acc_in),
        .acc_valid   (acc_valid),
        .acc_ready   (acc_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sat_flag    (sat_flag)
`ifdef FIR_ACC_READER_SATCNT_EN
        ,
        .sat_cnt_clr (sat_cnt_clr),
        .sat_cnt     (sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH:0] exp_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: round half up toward +inf with integer floor division, then clamp.
    function automatic logic [WIDTH:0] model(input longint a);
        longint one, hi, lo, s, q;
        logic sat;
        logic [WIDTH-1:0] d;
        one = longint'(1) << FRAC;
        hi  = (longint'(1) << (WIDTH - 1)) - 1;
        lo  = -hi - 1;
        s   = a + (one / 2);
        if (s >= 0) q = s / one;
        else        q = -((-s + one - 1) / one);
        sat = 1'b0;
        if (q > hi) begin
            q = hi;
            sat = 1'b1;
        end else if (q < lo) begin
            q = lo;
            sat = 1'b1;
        end
        d = WIDTH'(q);
        return {sat, d};
    endfunction

    // Scoreboard: samples handshakes just before each active edge.
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_data", longint'(out_data), longint'($signed(e[WIDTH-1:0])));
                    check("pop_sat", longint'(sat_flag), longint'(e[WIDTH]));
                end
            end
            if (acc_valid && acc_ready) exp_q.push_back(model(longint'(acc_in)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        acc_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick();
    endtask

    function automatic longint rand_acc();
        longint a;
        if ($urandom_range(0, 1) == 0) begin
            a = longint'($signed($urandom)) <<< $urandom_range(0, 6);
        end else begin
            a = (longint'($urandom_range(0, 65535)) - 32768) * 32768
                + longint'($urandom_range(16380, 16388));
        end
        return a;
    endfunction

    typedef struct {
        longint acc;
        longint data;
        logic   sat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int pops;
        int seen;
        longint a;

        vecs[0] = '{98304, 3, 1'b0};
        vecs[1] = '{114688, 4, 1'b0};
        vecs[2] = '{-16384, 0, 1'b0};
        vecs[3] = '{-16385, -1, 1'b0};
        vecs[4] = '{longint'(1) << 36, 32767, 1'b1};
        vecs[5] = '{-(longint'(1) << 36), -32768, 1'b1};
        vecs[6] = '{longint'(32767) << 15, 32767, 1'b0};
        vecs[7] = '{(longint'(32767) << 15) + 16384, 32767, 1'b1};
        vecs[8] = '{-(longint'(32768) << 15) - 16384, -32768, 1'b0};
        vecs[9] = '{-(longint'(32768) << 15) - 16385, -32768, 1'b1};

        rst = 1'b1;
        acc_valid = 1'b0;
        acc_in = '0;
        out_ready = 1'b0;
`ifdef FIR_ACC_READER_SATCNT_EN
        sat_cnt_clr = 1'b0;
`endif
        repeat (2) tick();
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_acc_ready", longint'(acc_ready), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_sat_flag", longint'(sat_flag), 0);
        rst = 1'b0;
        tick();
        check("idle_out_valid", longint'(out_valid), 0);
        check("idle_acc_ready", longint'(acc_ready), 1);
        check("idle_sat_flag", longint'(sat_flag), 0);

        // Single-sample vectors: latency of two edges, no bypass.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            acc_in = ACC_W'(vecs[i].acc);
            acc_valid = 1'b1;
            check("vec_ready", longint'(acc_ready), 1);
            tick();
            acc_valid = 1'b0;
            check("vec_no_bypass", longint'(out_valid), 0);
            tick();
            check("vec_valid", longint'(out_valid), 1);
            check("vec_data", longint'(out_data), vecs[i].data);
            check("vec_sat", longint'(sat_flag), longint'(vecs[i].sat));
            tick();
        end

        // Back-to-back rounding cases, checked by the scoreboard.
        for (int i = 0; i < 4; i++) begin
            acc_in = ACC_W'(vecs[i].acc);
            acc_valid = 1'b1;
            tick();
        end
        drain();

        // Backpressure: only DEPTH samples fit including the staged one.
        out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            acc_in = ACC_W'(longint'(i + 1) << FRAC);
            acc_valid = 1'b1;
            if (acc_ready) accepted++;
            tick();
        end
        acc_valid = 1'b0;
        check("bp_accepted", accepted, 4);
        check("bp_ready_low", longint'(acc_ready), 0);
        check("bp_head_hold", longint'(out_data), 1);
        tick();
        check("bp_head_hold2", longint'(out_data), 1);
        check("bp_valid_hold", longint'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        check("bp_ready_back", longint'(acc_ready), 1);
        drain();

        // Full FIFO, then continuous push and pop.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            acc_in = ACC_W'(rand_acc());
            acc_valid = 1'b1;
            tick();
        end
        acc_valid = 1'b0;
        tick();
        pops = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            acc_in = ACC_W'(rand_acc());
            acc_valid = 1'b1;
            if (out_valid && out_ready) pops++;
            tick();
        end
        check("full_pops", pops, 20);
        drain();
        check("full_no_loss", exp_q.size(), 0);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            a = rand_acc();
            acc_in = ACC_W'(a);
            acc_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        check("rand_no_loss", exp_q.size(), 0);

        // Mid-stream reset drops buffered samples.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            acc_in = ACC_W'(longint'(1) << 36);
            acc_valid = 1'b1;
            tick();
        end
        acc_valid = 1'b0;
        tick();
        check("mrst_buffered", longint'(out_valid), 1);
        rst = 1'b1;
        tick();
        check("mrst_valid", longint'(out_valid), 0);
`ifdef FIR_ACC_READER_SATCNT_EN
        check("satcnt_rst", longint'(sat_cnt), 0);
`endif
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            tick();
            if (out_valid) seen++;
        end
        check("mrst_no_old", seen, 0);

`ifdef FIR_ACC_READER_SATCNT_EN
        acc_in = ACC_W'(longint'(1) << 36);
        acc_valid = 1'b1;
        tick();
        acc_in = ACC_W'(-(longint'(1) << 36));
        tick();
        acc_in = ACC_W'(98304);
        tick();
        drain();
        check("satcnt_two", longint'(sat_cnt), 2);
        sat_cnt_clr = 1'b1;
        tick();
        sat_cnt_clr = 1'b0;
        check("satcnt_clr", longint'(sat_cnt), 0);
`endif

        drain();
        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
